// File: rtl/reg_bank_pkg.sv
// Shared sizing constants and FSM state type for the register bank arbiter.
package reg_bank_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/reg_bank.sv
// DEPTH x DATA_W register storage with one synchronous write port,
// a combinational read port sharing the same address, and async clear.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = reg_bank_pkg::DATA_W,
  parameter int DEPTH  = reg_bank_pkg::DEPTH,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear every register on reset, otherwise write the addressed word when enabled
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a small register bank.
// Each access takes two cycles: IDLE samples and latches the winner,
// ACCESS pulses its grant and commits the write or read on the way out.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = reg_bank_pkg::DATA_W,
  parameter int DEPTH  = reg_bank_pkg::DEPTH,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rid,
  output logic              busy
);

  state_t              state;
  state_t              next_state;
  logic                take;
  logic                winner;
  logic                last_id;
  logic                lat_we;
  logic                lat_id;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                bank_we;
  logic [DATA_W-1:0]   bank_rdata;

  // Next state and winner selection; a tie goes to whoever was not served last
  always_comb begin
    next_state = state;
    take       = 1'b0;
    winner     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          take       = 1'b1;
          next_state = ACCESS;
          winner     = (req0 && req1) ? ~last_id : req1;
        end
      end
      ACCESS: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the winner's operands and grant, and move the round-robin pointer
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      lat_we    <= 1'b0;
      lat_id    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      last_id   <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
    end else if (take) begin
      lat_we    <= winner ? we1 : we0;
      lat_id    <= winner;
      lat_addr  <= winner ? addr1 : addr0;
      lat_wdata <= winner ? wdata1 : wdata0;
      last_id   <= winner;
      gnt0      <= ~winner;
      gnt1      <= winner;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
    end
  end

  // Read result registers: strobe rvalid for one cycle, hold rdata otherwise
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      rid    <= 1'b0;
    end else if (state == ACCESS && !lat_we) begin
      rdata  <= bank_rdata;
      rvalid <= 1'b1;
      rid    <= lat_id;
    end else begin
      rvalid <= 1'b0;
    end
  end

  assign bank_we = (state == ACCESS) && lat_we;
  assign busy    = (state == ACCESS);

  reg_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .Clk    (Clk),
    .Resetn (Resetn),
    .we     (bank_we),
    .addr   (lat_addr),
    .wdata  (lat_wdata),
    .rdata  (bank_rdata)
  );

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed scenarios followed by random
// two-requester traffic, all checked against an access-level model.
module tb_reg_bank_arbiter;

  logic       Clk = 1'b0;
  logic       Resetn;
  logic       req0, req1, we0, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid, rid, busy;
  logic [7:0] rdata;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model: bank contents, the access in flight, expected outputs
  logic [7:0] mBank [4];
  bit         mBusy, mGnt0, mGnt1, mRvalid, mRid, mLast;
  logic [7:0] mRdata;
  bit         opWe, opId;
  logic [1:0] opAddr;
  logic [7:0] opData;

  reg_bank_arbiter dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .req0   (req0),
    .req1   (req1),
    .we0    (we0),
    .we1    (we1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rid    (rid),
    .busy   (busy)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r0, input bit w0, input logic [1:0] a0, input logic [7:0] d0,
                               input bit r1, input bit w1, input logic [1:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mBank[i] = 8'h00;
    mBusy = 0; mGnt0 = 0; mGnt1 = 0; mRvalid = 0; mRid = 0; mRdata = 8'h00;
    mLast = 1;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_gnt0"},   32'(gnt0),   32'(mGnt0));
    checkOutput({tag, "_gnt1"},   32'(gnt1),   32'(mGnt1));
    checkOutput({tag, "_busy"},   32'(busy),   32'(mBusy));
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'(mRvalid));
    checkOutput({tag, "_rdata"},  32'(rdata),  32'(mRdata));
    checkOutput({tag, "_rid"},    32'(rid),    32'(mRid));
  endtask

  // One clock: advance the model by the access rules, then compare outputs
  task automatic tick(input string tag);
    @(posedge Clk);
    if (mBusy) begin
      if (opWe) begin
        mBank[opAddr] = opData;
        mRvalid = 0;
      end else begin
        mRdata  = mBank[opAddr];
        mRid    = opId;
        mRvalid = 1;
      end
      mBusy = 0; mGnt0 = 0; mGnt1 = 0;
    end else begin
      mRvalid = 0;
      if (req0 || req1) begin
        opId   = (req0 && req1) ? !mLast : req1;
        opWe   = opId ? we1 : we0;
        opAddr = opId ? addr1 : addr0;
        opData = opId ? wdata1 : wdata0;
        mLast  = opId;
        mBusy  = 1;
        mGnt0  = !opId;
        mGnt1  = opId;
      end
    end
    #1;
    checkAll(tag);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    Resetn = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    @(posedge Clk);
    #2;
    Resetn = 1'b1;
  endtask

  initial begin
    int g0, g1;
    Resetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    doReset();

    // Write A5 to addr 2, read it back; first request right after reset release
    applyStimulus(1, 1, 2, 8'hA5, 0, 0, 0, 0);
    tick("wr_a5");
    checkOutput("wr_a5_gnt0", 32'(gnt0), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick("wr_a5_done");
    applyStimulus(1, 0, 2, 0, 0, 0, 0, 0);
    tick("rd_a5");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick("rd_a5_done");
    checkOutput("rd_a5_rdata", 32'(rdata), 32'h0A5);
    checkOutput("rd_a5_rvalid", 32'(rvalid), 32'd1);
    checkOutput("rd_a5_rid", 32'(rid), 32'd0);

    // Tie after reset: 0 wins, then held 1 wins, next tie goes to 0
    doReset();
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 0);
    tick("tie1");
    checkOutput("tie1_gnt0", 32'(gnt0), 32'd1);
    req0 = 0;
    tick("tie1_idle");
    tick("tie2");
    checkOutput("tie2_gnt1", 32'(gnt1), 32'd1);
    req1 = 0;
    tick("tie2_idle");
    req0 = 1; req1 = 1;
    tick("tie3");
    checkOutput("tie3_gnt0", 32'(gnt0), 32'd1);
    req0 = 0; req1 = 0;
    tick("tie3_idle");

    // Continuous contention: grants must alternate over 8 accesses
    g0 = 0; g1 = 0;
    applyStimulus(1, 0, 1, 0, 1, 0, 2, 0);
    for (int i = 0; i < 16; i++) begin
      tick("contend");
      g0 += int'(gnt0);
      g1 += int'(gnt1);
    end
    checkOutput("contend_g0", 32'(g0), 32'd4);
    checkOutput("contend_g1", 32'(g1), 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick("contend_end");

    // Operand change during ACCESS must not affect the latched write
    applyStimulus(1, 1, 3, 8'h11, 0, 0, 0, 0);
    tick("latch_wr");
    applyStimulus(0, 1, 3, 8'h22, 0, 0, 0, 0);
    tick("latch_wr_done");
    applyStimulus(1, 0, 3, 0, 0, 0, 0, 0);
    tick("latch_rd");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick("latch_rd_done");
    checkOutput("latch_rdata", 32'(rdata), 32'h011);

    // Reset in the middle of a write of FF to addr 1 aborts it
    applyStimulus(1, 1, 1, 8'hFF, 0, 0, 0, 0);
    tick("abort_wr");
    #2;
    Resetn = 1'b0;
    req0 = 0;
    #1;
    checkOutput("abort_gnt0", 32'(gnt0), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rvalid", 32'(rvalid), 32'd0);
    @(posedge Clk);
    #1;
    checkOutput("abort_rvalid2", 32'(rvalid), 32'd0);
    modelReset();
    #1;
    Resetn = 1'b1;
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    tick("abort_rd");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick("abort_rd_done");
    checkOutput("abort_bank1", 32'(rdata), 32'h000);
    checkOutput("abort_rd_rvalid", 32'(rvalid), 32'd1);

    // Quiet period: nothing should move
    for (int i = 0; i < 10; i++) tick("idle");

    // Random traffic obeying the hold-until-grant protocol
    for (int i = 0; i < 400; i++) begin
      tick("rand");
      if (req0 && gnt0) begin
        req0 = 0; we0 = 1'($urandom_range(0, 1));
        addr0 = 2'($urandom_range(0, 3)); wdata0 = 8'($urandom);
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; we0 = 1'($urandom_range(0, 1));
        addr0 = 2'($urandom_range(0, 3)); wdata0 = 8'($urandom);
      end
      if (req1 && gnt1) begin
        req1 = 0; we1 = 1'($urandom_range(0, 1));
        addr1 = 2'($urandom_range(0, 3)); wdata1 = 8'($urandom);
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; we1 = 1'($urandom_range(0, 1));
        addr1 = 2'($urandom_range(0, 3)); wdata1 = 8'($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register word width in bits.
REQ-002 Parameter DEPTH, default 4, number of registers; ADDR_W = clog2(DEPTH) = 2.
REQ-003 Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Resetn  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  access request from requester 0 and requester 1.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read, per requester.
REQ-007 addr0, addr1  input  ADDR_W each  register index, per requester.
REQ-008 wdata0, wdata1  input  DATA_W each  write data, per requester.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse, per requester.
REQ-010 rdata  output  DATA_W  read result.
REQ-011 rvalid  output  1  rdata valid strobe, one cycle.
REQ-012 rid  output  1  requester index owning the current rdata.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-015 In IDLE with any req high, the block SHALL select a winner, latch its we/addr/wdata, and move to ACCESS on the next edge.
REQ-016 In IDLE with both req low, the block SHALL remain in IDLE.
REQ-017 In ACCESS, the winner's gnt SHALL be high for exactly that cycle; the other gnt SHALL stay low.
REQ-018 ACCESS SHALL always return to IDLE on the next edge; peak throughput is one access per 2 cycles.
REQ-019 On the edge leaving ACCESS, a write SHALL update bank[addr] with the latched wdata.
REQ-020 On the edge leaving ACCESS, a read SHALL load rdata with bank[addr], set rvalid=1 and rid=winner for one cycle.
REQ-021 Latency: req sampled in cycle n gives gnt in n+1, and write visibility or rvalid in n+2.
REQ-022 On ties, arbitration SHALL be round-robin: grant the requester not served last; a single requester always wins.
REQ-023 The last-served pointer SHALL update only when a grant is issued.
REQ-024 Requests SHALL be sampled only in IDLE; req is ignored in ACCESS.
REQ-025 A requester SHALL hold req and operands until it sees its gnt high, and deassert req at that edge.
REQ-026 A req still high in the following IDLE SHALL be treated as a new request.
REQ-027 Operands SHALL be latched at the IDLE-to-ACCESS transition, so later input changes do not affect the access in flight.
REQ-028 rdata SHALL hold its last value while rvalid=0.
REQ-029 Writes do not drive rvalid.
REQ-030 A read following a write to the same address in a later access SHALL return the new value.
REQ-031 busy SHALL equal (state == ACCESS).

Reset
REQ-032 While Resetn=0, the block SHALL force:
- state = IDLE
- gnt0 = gnt1 = 0
- rvalid = 0, rid = 0, rdata = 0
- every bank register = 0
- last-served pointer = 1, so requester 0 wins the first tie.
REQ-033 Reset asserted during ACCESS SHALL abort it: no bank write and no rvalid pulse.
REQ-034 After Resetn rises, the first request SHALL be sampled at the first rising edge.

Structure
REQ-035 Package reg_bank_pkg SHALL hold DATA_W, DEPTH, ADDR_W and the state enum {IDLE, ACCESS}.
REQ-036 Storage SHALL be a sub-module reg_bank:
- DEPTH x DATA_W positive-edge flip-flops
- we/addr/wdata write port
- combinational read port
- asynchronous active-low clear.
REQ-037 Arbitration, the FSM and output registers SHALL reside in reg_bank_arbiter.

Verification
REQ-038 Single write then read: req0 writes 8'hA5 to addr 2, then req0 reads addr 2 -> gnt0 at n+1, rdata=8'hA5, rvalid=1, rid=0 at the read's n+2.
REQ-039 Tie after reset: req0 and req1 rise together -> gnt0 first; with req1 held, gnt1 on the next ACCESS; next tie -> gnt0.
REQ-040 Continuous contention: both req held high for 8 accesses -> grants alternate 0,1,0,1,...; no gnt in consecutive cycles.
REQ-041 Operand change after sampling: wdata0 changes from 8'h11 to 8'h22 during ACCESS -> bank stores 8'h11.
REQ-042 Reset mid-ACCESS: Resetn low during a write of 8'hFF to addr 1 -> bank[1]=0, no rvalid, gnt low, busy=0.
REQ-043 Idle check: no req for 10 cycles -> busy=0, gnt0=gnt1=0, rvalid=0 throughout.
